// File: rtl/opll_vgm_pkg.sv
// ============================================================================
// Module   : opll_vgm_pkg
// Contents : Shared command/state encodings and default bus timing constants
//            for the VGM-driven OPLL bus writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package opll_vgm_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'd0,
    CMD_WAIT  = 2'd1,
    CMD_END   = 2'd2,
    CMD_NOP   = 2'd3
  } cmd_type_t;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADR_SETUP = 4'd1,
    ST_ADR_PULSE = 4'd2,
    ST_ADR_HOLD  = 4'd3,
    ST_DAT_SETUP = 4'd4,
    ST_DAT_PULSE = 4'd5,
    ST_DAT_HOLD  = 4'd6,
    ST_WAIT      = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  localparam int WR_PULSE  = 2;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;
  localparam int VGM_RATE  = 44100;
  localparam int OPLL_CLK  = 3579545;

endpackage

`default_nettype wire

// File: rtl/opll_sample_tick.sv
// ============================================================================
// Module   : opll_sample_tick
// Function : Fractional accumulator divider; one-clock pulse at an average
//            rate of SMP_NUM/SMP_DEN per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opll_sample_tick #(
  parameter int SMP_NUM = opll_vgm_pkg::VGM_RATE,
  parameter int SMP_DEN = opll_vgm_pkg::OPLL_CLK
) (
  input  logic i_EMUCLK,
  input  logic i_RST,
  output logic o_SMP_TICK
);

  localparam int               c_ACC_W = $clog2(SMP_DEN) + 1;
  localparam logic [c_ACC_W-1:0] c_NUM = c_ACC_W'(SMP_NUM);
  localparam logic [c_ACC_W-1:0] c_DEN = c_ACC_W'(SMP_DEN);

  logic [c_ACC_W-1:0] acc_q, acc_d, w_sum;
  logic               tick_q, tick_d;

  // Wrap subtracts the full modulus so the long-run rate carries no drift.
  always_comb begin
    w_sum  = acc_q + c_NUM;
    acc_d  = w_sum;
    tick_d = 1'b0;
    if (w_sum >= c_DEN) begin
      acc_d  = w_sum - c_DEN;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign o_SMP_TICK = tick_q;

endmodule

`default_nettype wire

// File: rtl/opll_vgm_bus_writer.sv
// ============================================================================
// Module   : opll_vgm_bus_writer
// Function : VGM WRITE/WAIT/END command player driving the OPLL CPU bus with
//            phiM-timed address/data cycles and 44.1 kHz sample pacing.
//            Optional OPLL_VGM_WRCNT_EN adds write/sample statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opll_vgm_bus_writer #(
  parameter int WR_PULSE  = opll_vgm_pkg::WR_PULSE,
  parameter int ADDR_WAIT = opll_vgm_pkg::ADDR_WAIT,
  parameter int DATA_WAIT = opll_vgm_pkg::DATA_WAIT,
  parameter int SMP_NUM   = opll_vgm_pkg::VGM_RATE,
  parameter int SMP_DEN   = opll_vgm_pkg::OPLL_CLK
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_phiM_PCEN_n,
  input  logic        i_CMD_VALID,
  output logic        o_CMD_READY,
  input  logic [1:0]  i_CMD_TYPE,
  input  logic [15:0] i_CMD_ARG,
  output logic        o_CS_n,
  output logic        o_WR_n,
  output logic        o_A0,
  output logic [7:0]  o_D,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_SMP_TICK
`ifdef OPLL_VGM_WRCNT_EN
  ,
  output logic [15:0] o_WR_COUNT,
  output logic [31:0] o_SMP_COUNT
`endif
);

  import opll_vgm_pkg::*;

  localparam logic [15:0] c_PULSE_LD = 16'(WR_PULSE - 1);
  localparam logic [15:0] c_ADDR_LD  = 16'(ADDR_WAIT - 1);
  localparam logic [15:0] c_DATA_LD  = 16'(DATA_WAIT - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  dat_q;
  logic        strobe_n_q;
  logic        a0_q;
  logic [7:0]  d_q;
  logic        ready_q;
  logic        done_q;

  logic        w_pe;
  logic        w_tick;
  logic        w_accept;

  assign w_pe     = !i_phiM_PCEN_n;
  assign w_accept = i_CMD_VALID && ready_q;

  opll_sample_tick #(
    .SMP_NUM (SMP_NUM),
    .SMP_DEN (SMP_DEN)
  ) u_tick (
    .i_EMUCLK   (i_EMUCLK),
    .i_RST      (i_RST),
    .o_SMP_TICK (w_tick)
  );

  // Each timed state loads cnt_q with (duration-1) and leaves on the pe where it is 0.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dat_q      <= '0;
      strobe_n_q <= 1'b1;
      a0_q       <= 1'b0;
      d_q        <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ready_q <= (state_q == ST_IDLE) && !w_accept;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            case (cmd_type_t'(i_CMD_TYPE))
              CMD_WRITE: begin
                state_q <= ST_ADR_SETUP;
                a0_q    <= 1'b0;
                d_q     <= i_CMD_ARG[15:8];
                dat_q   <= i_CMD_ARG[7:0];
                cnt_q   <= '0;
              end
              CMD_WAIT: begin
                state_q <= ST_WAIT;
                cnt_q   <= i_CMD_ARG;
              end
              CMD_END: begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WAIT: begin
          if (w_tick && cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd0 || (w_tick && cnt_q == 16'd1)) state_q <= ST_IDLE;
        end
        ST_DONE: ;
        default: begin
          if (w_pe) begin
            if (cnt_q != 16'd0) begin
              cnt_q <= cnt_q - 16'd1;
            end else begin
              case (state_q)
                ST_ADR_SETUP: begin
                  state_q    <= ST_ADR_PULSE;
                  strobe_n_q <= 1'b0;
                  cnt_q      <= c_PULSE_LD;
                end
                ST_ADR_PULSE: begin
                  state_q    <= ST_ADR_HOLD;
                  strobe_n_q <= 1'b1;
                  cnt_q      <= c_ADDR_LD;
                end
                ST_ADR_HOLD: begin
                  state_q <= ST_DAT_SETUP;
                  a0_q    <= 1'b1;
                  d_q     <= dat_q;
                  cnt_q   <= '0;
                end
                ST_DAT_SETUP: begin
                  state_q    <= ST_DAT_PULSE;
                  strobe_n_q <= 1'b0;
                  cnt_q      <= c_PULSE_LD;
                end
                ST_DAT_PULSE: begin
                  state_q    <= ST_DAT_HOLD;
                  strobe_n_q <= 1'b1;
                  cnt_q      <= c_DATA_LD;
                end
                default: begin
                  state_q    <= ST_IDLE;
                  strobe_n_q <= 1'b1;
                  d_q        <= '0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign o_CMD_READY = ready_q;
  assign o_CS_n      = strobe_n_q;
  assign o_WR_n      = strobe_n_q;
  assign o_A0        = a0_q;
  assign o_D         = d_q;
  assign o_BUSY      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_DONE      = done_q;
  assign o_SMP_TICK  = w_tick;

`ifdef OPLL_VGM_WRCNT_EN
  logic [15:0] wr_count_q;
  logic [31:0] smp_count_q;

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      wr_count_q  <= '0;
      smp_count_q <= '0;
    end else begin
      if (state_q == ST_DAT_HOLD && w_pe && cnt_q == 16'd0) wr_count_q <= wr_count_q + 16'd1;
      if (state_q == ST_WAIT && w_tick && cnt_q != 16'd0) smp_count_q <= smp_count_q + 32'd1;
    end
  end

  assign o_WR_COUNT  = wr_count_q;
  assign o_SMP_COUNT = smp_count_q;
`endif

endmodule

`default_nettype wire
